// File: rtl/addsub32_pipe.sv
// Two-stage pipelined add/subtract unit split into two halves.
// Low half and its carry in stage 1, high half and flags in stage 2.
module addsub32_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int HALF = WIDTH / 2;

    logic            s1_valid;
    logic [HALF-1:0] s1_lo;
    logic            s1_c16;
    logic [HALF-1:0] s1_ahi;
    logic [HALF-1:0] s1_bxhi;

    logic             s2_adv;
    logic             s1_adv;
    logic             accept;
    logic [WIDTH-1:0] bx;
    logic [HALF:0]    lo_sum;
    logic [HALF:0]    hi_sum;
    logic [WIDTH-1:0] res;
    logic             ovf;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_adv;
    assign in_ready = !s1_valid || s2_adv;
    assign accept   = in_valid && in_ready;

    // Stage 1 datapath: invert B for subtract, add low halves with sub as carry-in.
    always_comb begin
        bx     = sub ? ~input2 : input2;
        lo_sum = {1'b0, input1[HALF-1:0]}
               + {1'b0, bx[HALF-1:0]}
               + {{HALF{1'b0}}, sub};
    end

    // Stage 2 datapath: high halves plus registered carry, then signed overflow.
    always_comb begin
        hi_sum = {1'b0, s1_ahi}
               + {1'b0, s1_bxhi}
               + {{HALF{1'b0}}, s1_c16};
        res    = {hi_sum[HALF-1:0], s1_lo};
        ovf    = (s1_ahi[HALF-1] == s1_bxhi[HALF-1])
              && (res[WIDTH-1] != s1_ahi[HALF-1]);
    end

    // Stage 1 registers: occupancy follows in_valid whenever the slot can move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_lo    <= '0;
            s1_c16   <= 1'b0;
            s1_ahi   <= '0;
            s1_bxhi  <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (accept) begin
                s1_lo   <= lo_sum[HALF-1:0];
                s1_c16  <= lo_sum[HALF];
                s1_ahi  <= input1[WIDTH-1:HALF];
                s1_bxhi <= bx[WIDTH-1:HALF];
            end
        end
    end

    // Stage 2 registers: result and flags load together and hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else begin
            if (s2_adv) begin
                out_valid <= s1_valid;
            end
            if (s1_adv) begin
                out       <= res;
                carry_out <= hi_sum[HALF];
                overflow  <= ovf;
                zero      <= (res == '0);
                negative  <= res[WIDTH-1];
            end
        end
    end

endmodule
